// File: rtl/cv_pkg.sv
// Shared constants for the VRAM copy path: step codes issued by the copy state
// machine and the VRAM pair/line address widths.
package cv_pkg;

  localparam int VRAM_PAIR_W = 9;
  localparam int VRAM_LINE_W = 9;

  localparam logic [2:0] X_ASIS     = 3'd0;
  localparam logic [2:0] X_TRI_NEXT = 3'd1;
  localparam logic [2:0] X_CV_START = 3'd6;

  localparam logic [2:0] Y_ASIS     = 3'd0;
  localparam logic [2:0] Y_TRI_NEXT = 3'd4;
  localparam logic [2:0] Y_CV_ZERO  = 3'd6;

  typedef enum logic {
    ST_IDLE,
    ST_WALK
  } walk_st_e;

  // Index of the last 32-bit pair touched by a row of w_eff pixels starting at
  // a pixel of parity src_x0; w_eff is 1..1024 so the result is 0..512.
  function automatic logic [9:0] last_pair_f(input logic src_x0, input logic [10:0] w_eff);
    return 10'(({10'd0, src_x0} + w_eff - 11'd1) >> 1);
  endfunction

endpackage

// File: rtl/cv_wrap_add.sv
// Origin-plus-counter add that wraps modulo the VRAM pair/line range.
// Purely combinational, no handshake.
module cv_wrap_add #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_offs,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_base + i_offs;

endmodule

// File: rtl/cv_copy_coord_walker.sv
// Latches a VRAM-to-VRAM copy rectangle and walks source/destination pair addresses
// under step codes; state updates one cycle after the code, flags are same-cycle decodes.
module cv_copy_coord_walker
  import cv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [9:0]  i_srcX,
  input  logic [8:0]  i_srcY,
  input  logic [9:0]  i_dstX,
  input  logic [8:0]  i_dstY,
  input  logic [9:0]  i_width,
  input  logic [8:0]  i_height,
  input  logic [2:0]  i_nextX,
  input  logic [2:0]  i_nextY,
  input  logic        i_exit,
  output logic        o_active,
  output logic        o_isWidthNot1,
  output logic        o_xb0,
  output logic        o_wb0,
  output logic [17:0] o_srcAddr,
  output logic [17:0] o_dstAddr,
  output logic [1:0]  o_wrMask,
  output logic        o_currPairIsLineLast,
  output logic        o_nextPairIsLineLast,
  output logic        o_endVertical
);

  walk_st_e               st_q, st_d;
  logic [VRAM_PAIR_W-1:0] src_pair0_q, src_pair0_d;
  logic [VRAM_PAIR_W-1:0] dst_pair0_q, dst_pair0_d;
  logic [VRAM_LINE_W-1:0] src_line0_q, src_line0_d;
  logic [VRAM_LINE_W-1:0] dst_line0_q, dst_line0_d;
  logic                   dst_x0_q, dst_x0_d;
  logic                   dst_end_odd_q, dst_end_odd_d;
  logic [9:0]             last_pair_q, last_pair_d;
  logic [VRAM_LINE_W-1:0] last_line_q, last_line_d;
  logic [9:0]             pair_cnt_q, pair_cnt_d;
  logic [VRAM_LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic                   xb0_q, xb0_d;
  logic                   wb0_q, wb0_d;
  logic                   width_not1_q, width_not1_d;

  logic [10:0] w_eff;
  logic        active;
  logic        curr_last;
  logic        next_last;

  assign w_eff  = (i_width == 10'd0) ? 11'd1024 : {1'b0, i_width};
  assign active = (st_q == ST_WALK);

  always_comb begin
    st_d          = st_q;
    src_pair0_d   = src_pair0_q;
    dst_pair0_d   = dst_pair0_q;
    src_line0_d   = src_line0_q;
    dst_line0_d   = dst_line0_q;
    dst_x0_d      = dst_x0_q;
    dst_end_odd_d = dst_end_odd_q;
    last_pair_d   = last_pair_q;
    last_line_d   = last_line_q;
    pair_cnt_d    = pair_cnt_q;
    line_cnt_d    = line_cnt_q;
    xb0_d         = xb0_q;
    wb0_d         = wb0_q;
    width_not1_d  = width_not1_q;

    if (!active) begin
      if (i_start) begin
        st_d          = ST_WALK;
        src_pair0_d   = i_srcX[9:1];
        dst_pair0_d   = i_dstX[9:1];
        src_line0_d   = i_srcY;
        dst_line0_d   = i_dstY;
        dst_x0_d      = i_dstX[0];
        // Parity of the rightmost destination pixel, dstX + wEff - 1.
        dst_end_odd_d = i_dstX[0] ^ ~w_eff[0];
        last_pair_d   = last_pair_f(i_srcX[0], w_eff);
        // Height 0 encodes 512, so the wrapping subtract lands on 511 naturally.
        last_line_d   = i_height - 9'd1;
        pair_cnt_d    = 10'd0;
        line_cnt_d    = '0;
        xb0_d         = i_srcX[0] ^ i_dstX[0];
        wb0_d         = w_eff[0];
        width_not1_d  = (w_eff != 11'd1);
      end
    end else begin
      case (i_nextX)
        X_TRI_NEXT: pair_cnt_d = pair_cnt_q + 10'd1;
        X_CV_START: pair_cnt_d = 10'd0;
        default:    pair_cnt_d = pair_cnt_q;
      endcase
      case (i_nextY)
        Y_TRI_NEXT: line_cnt_d = line_cnt_q + 9'd1;
        Y_CV_ZERO:  line_cnt_d = '0;
        default:    line_cnt_d = line_cnt_q;
      endcase
      if (i_exit) begin
        st_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= ST_IDLE;
      src_pair0_q   <= '0;
      dst_pair0_q   <= '0;
      src_line0_q   <= '0;
      dst_line0_q   <= '0;
      dst_x0_q      <= 1'b0;
      dst_end_odd_q <= 1'b0;
      last_pair_q   <= '0;
      last_line_q   <= '0;
      pair_cnt_q    <= '0;
      line_cnt_q    <= '0;
      xb0_q         <= 1'b0;
      wb0_q         <= 1'b0;
      width_not1_q  <= 1'b0;
    end else begin
      st_q          <= st_d;
      src_pair0_q   <= src_pair0_d;
      dst_pair0_q   <= dst_pair0_d;
      src_line0_q   <= src_line0_d;
      dst_line0_q   <= dst_line0_d;
      dst_x0_q      <= dst_x0_d;
      dst_end_odd_q <= dst_end_odd_d;
      last_pair_q   <= last_pair_d;
      last_line_q   <= last_line_d;
      pair_cnt_q    <= pair_cnt_d;
      line_cnt_q    <= line_cnt_d;
      xb0_q         <= xb0_d;
      wb0_q         <= wb0_d;
      width_not1_q  <= width_not1_d;
    end
  end

  logic [VRAM_PAIR_W-1:0] src_pair, dst_pair;
  logic [VRAM_LINE_W-1:0] src_line, dst_line;

  cv_wrap_add #(.W(VRAM_PAIR_W)) u_src_pair (
    .i_base (src_pair0_q),
    .i_offs (pair_cnt_q[VRAM_PAIR_W-1:0]),
    .o_sum  (src_pair)
  );

  cv_wrap_add #(.W(VRAM_PAIR_W)) u_dst_pair (
    .i_base (dst_pair0_q),
    .i_offs (pair_cnt_q[VRAM_PAIR_W-1:0]),
    .o_sum  (dst_pair)
  );

  cv_wrap_add #(.W(VRAM_LINE_W)) u_src_line (
    .i_base (src_line0_q),
    .i_offs (line_cnt_q),
    .o_sum  (src_line)
  );

  cv_wrap_add #(.W(VRAM_LINE_W)) u_dst_line (
    .i_base (dst_line0_q),
    .i_offs (line_cnt_q),
    .o_sum  (dst_line)
  );

  assign curr_last = (pair_cnt_q == last_pair_q);
  assign next_last = ((pair_cnt_q + 10'd1) == last_pair_q);

  assign o_active             = active;
  assign o_isWidthNot1        = width_not1_q;
  assign o_xb0                = xb0_q;
  assign o_wb0                = wb0_q;
  assign o_srcAddr            = {src_line, src_pair};
  assign o_dstAddr            = {dst_line, dst_pair};
  assign o_currPairIsLineLast = active & curr_last;
  assign o_nextPairIsLineLast = active & next_last;
  assign o_endVertical        = active & (line_cnt_q == last_line_q);

  // Trim the partial pixel at each end of the destination row.
  always_comb begin
    o_wrMask = 2'b00;
    if (active) begin
      o_wrMask[0] = !((pair_cnt_q == 10'd0) && dst_x0_q);
      o_wrMask[1] = !(curr_last && !dst_end_odd_q);
    end
  end

endmodule

// File: tb/tb_cv_copy_coord_walker.sv
// Directed bench for cv_copy_coord_walker with hand-computed expectations.
module tb_cv_copy_coord_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [9:0]  i_srcX, i_dstX, i_width;
  logic [8:0]  i_srcY, i_dstY, i_height;
  logic [2:0]  i_nextX, i_nextY;
  logic        i_exit;
  logic        o_active, o_isWidthNot1, o_xb0, o_wb0;
  logic [17:0] o_srcAddr, o_dstAddr;
  logic [1:0]  o_wrMask;
  logic        o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv_copy_coord_walker dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_start              (i_start),
    .i_srcX               (i_srcX),
    .i_srcY               (i_srcY),
    .i_dstX               (i_dstX),
    .i_dstY               (i_dstY),
    .i_width              (i_width),
    .i_height             (i_height),
    .i_nextX              (i_nextX),
    .i_nextY              (i_nextY),
    .i_exit               (i_exit),
    .o_active             (o_active),
    .o_isWidthNot1        (o_isWidthNot1),
    .o_xb0                (o_xb0),
    .o_wb0                (o_wb0),
    .o_srcAddr            (o_srcAddr),
    .o_dstAddr            (o_dstAddr),
    .o_wrMask             (o_wrMask),
    .o_currPairIsLineLast (o_currPairIsLineLast),
    .o_nextPairIsLineLast (o_nextPairIsLineLast),
    .o_endVertical        (o_endVertical)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [9:0] sx, input logic [8:0] sy,
                           input logic [9:0] dx, input logic [8:0] dy,
                           input logic [9:0] w,  input logic [8:0] h);
    i_srcX = sx; i_srcY = sy; i_dstX = dx; i_dstY = dy; i_width = w; i_height = h;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic step(input logic [2:0] xc, input logic [2:0] yc);
    i_nextX = xc; i_nextY = yc;
    tick();
    i_nextX = 3'd0; i_nextY = 3'd0;
  endtask

  task automatic do_exit();
    i_exit = 1'b1;
    tick();
    i_exit = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_active"},  {31'd0, o_active}, 32'd0);
    chk({pfx, "_src"},     {14'd0, o_srcAddr}, 32'd0);
    chk({pfx, "_dst"},     {14'd0, o_dstAddr}, 32'd0);
    chk({pfx, "_mask"},    {30'd0, o_wrMask}, 32'd0);
    chk({pfx, "_flags"},   {26'd0, o_xb0, o_wb0, o_isWidthNot1, o_currPairIsLineLast,
                            o_nextPairIsLineLast, o_endVertical}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_exit = 1'b0; i_nextX = 3'd0; i_nextY = 3'd0;
    i_srcX = '0; i_srcY = '0; i_dstX = '0; i_dstY = '0; i_width = '0; i_height = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("rst");

    // Aligned copy: src(0,0), dst(4,3), 4x2 -> lastPair 1, dst pair 2 line 3.
    start_cmd(10'd0, 9'd0, 10'd4, 9'd3, 10'd4, 9'd2);
    chk("a_active", {31'd0, o_active}, 32'd1);
    chk("a_src0",   {14'd0, o_srcAddr}, 32'h00000);
    chk("a_dst0",   {14'd0, o_dstAddr}, 32'h00602);
    chk("a_flags0", {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b010);
    chk("a_misc",   {29'd0, o_isWidthNot1, o_xb0, o_wb0}, 32'b100);
    chk("a_mask0",  {30'd0, o_wrMask}, 32'd3);
    step(3'd1, 3'd0);
    chk("a_src1",   {14'd0, o_srcAddr}, 32'h00001);
    chk("a_dst1",   {14'd0, o_dstAddr}, 32'h00603);
    chk("a_flags1", {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b100);
    chk("a_mask1",  {30'd0, o_wrMask}, 32'd3);
    step(3'd6, 3'd4);
    chk("a_src2",   {14'd0, o_srcAddr}, 32'h00200);
    chk("a_dst2",   {14'd0, o_dstAddr}, 32'h00802);
    chk("a_flags2", {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b011);
    do_exit();
    chk("a_exit",   {31'd0, o_active}, 32'd0);
    chk("a_exmask", {30'd0, o_wrMask}, 32'd0);

    // Unaligned: src(1,5), dst(2,7), w=3 h=1 -> lastPair 1, dst end pixel 4 even.
    start_cmd(10'd1, 9'd5, 10'd2, 9'd7, 10'd3, 9'd1);
    chk("u_misc",   {29'd0, o_isWidthNot1, o_xb0, o_wb0}, 32'b111);
    chk("u_src0",   {14'd0, o_srcAddr}, 32'h00A00);
    chk("u_dst0",   {14'd0, o_dstAddr}, 32'h00E01);
    chk("u_mask0",  {30'd0, o_wrMask}, 32'd3);
    chk("u_endv",   {31'd0, o_endVertical}, 32'd1);
    step(3'd1, 3'd0);
    chk("u_src1",   {14'd0, o_srcAddr}, 32'h00A01);
    chk("u_dst1",   {14'd0, o_dstAddr}, 32'h00E02);
    chk("u_mask1",  {30'd0, o_wrMask}, 32'd1);
    chk("u_curr1",  {31'd0, o_currPairIsLineLast}, 32'd1);
    do_exit();

    // Wrap: src(1022,511), w=4 h=2 -> pair 511 then 0, line 511 then 0.
    start_cmd(10'd1022, 9'd511, 10'd0, 9'd0, 10'd4, 9'd2);
    chk("w_src0",   {14'd0, o_srcAddr}, 32'h3FFFF);
    step(3'd1, 3'd4);
    chk("w_src1",   {14'd0, o_srcAddr}, 32'h00000);
    chk("w_dst1",   {14'd0, o_dstAddr}, 32'h00201);
    // Start while active must not relatch.
    start_cmd(10'd100, 9'd100, 10'd100, 9'd100, 10'd8, 9'd8);
    chk("w_norelatch", {14'd0, o_srcAddr}, 32'h00000);
    chk("w_stillact",  {31'd0, o_active}, 32'd1);
    // Start and exit together: exit wins.
    i_exit = 1'b1;
    start_cmd(10'd100, 9'd100, 10'd100, 9'd100, 10'd8, 9'd8);
    i_exit = 1'b0;
    chk("w_sx_act", {31'd0, o_active}, 32'd0);
    chk("w_sx_src", {14'd0, o_srcAddr}, 32'h00000);

    // Max size: src(1,0), dst(1,0), w=1024 h=512 -> lastPair 512, last line 511.
    start_cmd(10'd1, 9'd0, 10'd1, 9'd0, 10'd0, 9'd0);
    chk("m_misc",   {29'd0, o_isWidthNot1, o_xb0, o_wb0}, 32'b100);
    chk("m_mask0",  {30'd0, o_wrMask}, 32'd2);
    chk("m_endv0",  {31'd0, o_endVertical}, 32'd0);
    for (int i = 0; i < 510; i++) step(3'd1, 3'd4);
    chk("m_flags510", {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b000);
    step(3'd1, 3'd4);
    chk("m_flags511", {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b011);
    step(3'd1, 3'd0);
    chk("m_flags512", {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b101);
    chk("m_mask512",  {30'd0, o_wrMask}, 32'd1);
    chk("m_src512",   {14'd0, o_srcAddr}, 32'h3FE00);
    chk("m_dst512",   {14'd0, o_dstAddr}, 32'h3FE00);

    // Reset mid-walk, then a fresh 1x1 command.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("mid");
    start_cmd(10'd0, 9'd2, 10'd0, 9'd1, 10'd1, 9'd1);
    chk("r_active", {31'd0, o_active}, 32'd1);
    chk("r_misc",   {29'd0, o_isWidthNot1, o_xb0, o_wb0}, 32'b001);
    chk("r_flags",  {29'd0, o_currPairIsLineLast, o_nextPairIsLineLast, o_endVertical}, 32'b101);
    chk("r_mask",   {30'd0, o_wrMask}, 32'd1);
    chk("r_src",    {14'd0, o_srcAddr}, 32'h00400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
